tbre_mmreg_mc: RTL and testbench



---
 rtl/tbre_mmreg_mc.sv | 200 ++++++++++++++++++++
 tb/tb_tbre_mmreg_mc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbre_mmreg_mc.sv
// tbre_mmreg_mc: multi-channel MMIO control/status block for the TBRE.
// Each channel has START/END shadows, a launch FSM, an epoch counter and
// maskable done/err/ovf interrupts. Address [7:5] = channel, [4:2] = register.
// Optional feature macro: TBRE_MMREG_TIMEOUT_EN (WAITB timeout and TO_LIMIT).
module tbre_mmreg_mc #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned EPOCH_W = 16,
  parameter int unsigned TO_W    = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              reg_en_i,
  input  logic [31:0]       reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  input  logic              reg_we_i,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_ready_o,
  input  logic [NCH-1:0]    tbre_busy_i,
  output logic [NCH*65-1:0] tbre_corein_o,
  output logic              tbre_intr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KICK  = 2'd1,
    S_WAITB = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  logic [2:0]     ch_idx;
  logic [2:0]     reg_idx;
  logic [31:0]    ch_rd [NCH];
  logic [NCH-1:0] ch_intr;
  logic [31:0]    rd_val;
  logic           unused_addr;

  assign ch_idx      = reg_addr_i[7:5];
  assign reg_idx     = reg_addr_i[4:2];
  assign unused_addr = ^{reg_addr_i[31:8], reg_addr_i[1:0]};
  assign reg_ready_o = 1'b1;

`ifndef TBRE_MMREG_TIMEOUT_EN
  localparam int unsigned unused_to_w = TO_W;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t             state, state_nxt;
    logic               wr, req, load, epoch_inc;
    logic               pend, pend_nxt, busy_q;
    logic [31:0]        sh_start, sh_end, co_start, co_end, rd_ch;
    logic [EPOCH_W-1:0] epoch;
    logic [2:0]         intr_stat, intr_en, hw_set, w1c;
`ifdef TBRE_MMREG_TIMEOUT_EN
    logic [TO_W-1:0]    to_limit, to_cnt;
    logic               cnt_clr, cnt_inc;
`endif

    assign wr  = reg_en_i && reg_we_i && (ch_idx == 3'(c));
    assign req = wr && (reg_idx == 3'd2);
    assign w1c = (wr && (reg_idx == 3'd4)) ? reg_wdata_i[2:0] : 3'b000;

    // Launch FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= state_nxt;
    end

    // Launch FSM next state, pending-launch bookkeeping and event flags
    always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      load      = 1'b0;
      epoch_inc = 1'b0;
      hw_set    = '0;
`ifdef TBRE_MMREG_TIMEOUT_EN
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req || pend) begin
            state_nxt = S_KICK;
            load      = 1'b1;
            // a fresh request arriving while a queued one launches stays queued
            pend_nxt  = req && pend;
          end
        end
        S_KICK: begin
          state_nxt = S_WAITB;
`ifdef TBRE_MMREG_TIMEOUT_EN
          cnt_clr   = 1'b1;
`endif
        end
        S_WAITB: begin
          if (tbre_busy_i[c]) state_nxt = S_BUSY;
`ifdef TBRE_MMREG_TIMEOUT_EN
          else if (to_cnt == to_limit) begin
            hw_set[1] = 1'b1;
            state_nxt = S_IDLE;
          end
          else cnt_inc = 1'b1;
`endif
        end
        S_BUSY: begin
          if (busy_q && !tbre_busy_i[c]) begin
            epoch_inc = 1'b1;
            hw_set[0] = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      if (req && (state != S_IDLE)) begin
        if (pend) hw_set[2] = 1'b1;
        else      pend_nxt  = 1'b1;
      end
    end

    // Channel registers, core-facing address latch, epoch and interrupt status
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sh_start  <= '0;
        sh_end    <= '0;
        co_start  <= '0;
        co_end    <= '0;
        pend      <= 1'b0;
        busy_q    <= 1'b0;
        epoch     <= '0;
        intr_stat <= '0;
        intr_en   <= '0;
`ifdef TBRE_MMREG_TIMEOUT_EN
        to_limit  <= '1;
        to_cnt    <= '0;
`endif
      end else begin
        pend      <= pend_nxt;
        busy_q    <= tbre_busy_i[c];
        intr_stat <= (intr_stat & ~w1c) | hw_set;
        if (load) begin
          co_start <= sh_start;
          co_end   <= sh_end;
        end
        if (epoch_inc) epoch <= epoch + EPOCH_W'(1);
        if (wr) begin
          case (reg_idx)
            3'd0: sh_start <= reg_wdata_i;
            3'd1: sh_end   <= reg_wdata_i;
            3'd5: intr_en  <= reg_wdata_i[2:0];
`ifdef TBRE_MMREG_TIMEOUT_EN
            3'd6: to_limit <= reg_wdata_i[TO_W-1:0];
`endif
            default: ;
          endcase
        end
`ifdef TBRE_MMREG_TIMEOUT_EN
        if (cnt_clr)      to_cnt <= '0;
        else if (cnt_inc) to_cnt <= to_cnt + TO_W'(1);
`endif
      end
    end

    // Per-channel read mux
    always_comb begin
      rd_ch = '0;
      case (reg_idx)
        3'd0: rd_ch = sh_start;
        3'd1: rd_ch = sh_end;
        3'd2: rd_ch = {16'h5501, 12'h000, pend, 1'b0, state};
        3'd3: rd_ch = {31'(epoch), tbre_busy_i[c]};
        3'd4: rd_ch = {29'd0, intr_stat};
        3'd5: rd_ch = {29'd0, intr_en};
`ifdef TBRE_MMREG_TIMEOUT_EN
        3'd6: rd_ch = 32'(to_limit);
`endif
        default: rd_ch = '0;
      endcase
    end

    assign ch_rd[c]                 = rd_ch;
    assign ch_intr[c]               = |(intr_stat & intr_en);
    assign tbre_corein_o[65*c +: 65] = {(state == S_KICK), co_end, co_start};
  end

  // Channel select for reads; channels >= NCH read as zero
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_idx == 3'(i)) rd_val = ch_rd[i];
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                    reg_rdata_o <= '0;
    else if (reg_en_i && !reg_we_i) reg_rdata_o <= rd_val;
  end

  assign tbre_intr_o = |ch_intr;

endmodule

// File: tb/tb_tbre_mmreg_mc.sv
// Scoreboard bench for tbre_mmreg_mc: directed scenarios followed by random
// traffic, checked every cycle against a behavioural reference model.
module tb_tbre_mmreg_mc;
  localparam int NCH     = 2;
  localparam int EPOCH_W = 2;
  localparam int TO_W    = 12;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              reg_en_i, reg_we_i, reg_ready_o, tbre_intr_o;
  logic [31:0]       reg_addr_i, reg_wdata_i, reg_rdata_o;
  logic [NCH-1:0]    tbre_busy_i;
  logic [NCH*65-1:0] tbre_corein_o;

  tbre_mmreg_mc #(.NCH(NCH), .EPOCH_W(EPOCH_W), .TO_W(TO_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .reg_en_i(reg_en_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_rdata_o(reg_rdata_o),
    .reg_ready_o(reg_ready_o), .tbre_busy_i(tbre_busy_i),
    .tbre_corein_o(tbre_corein_o), .tbre_intr_o(tbre_intr_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one record per channel, mode numbers as seen in CTRL
  typedef struct {
    logic [31:0] sh_start, sh_end, co_start, co_end;
    int          st;       // 0 idle, 1 kick, 2 wait for busy, 3 busy
    bit          pend;
    int          epoch;
    bit          bprev;
    logic [2:0]  stat, ien;
    int          tolim, cnt;
  } mch_t;

  typedef struct {
    int                cyc;
    logic [NCH*65-1:0] corein;
    logic              intr;
    logic [31:0]       rdata;
  } exp_t;

  mch_t           m [NCH];
  logic [31:0]    m_rdata;
  exp_t           exp_q [$];
  logic [NCH-1:0] busy_v;
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  function automatic void chk(string nm, logic [159:0] act, logic [159:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m[i].sh_start = '0; m[i].sh_end = '0; m[i].co_start = '0; m[i].co_end = '0;
      m[i].st = 0; m[i].pend = 0; m[i].epoch = 0; m[i].bprev = 0;
      m[i].stat = '0; m[i].ien = '0; m[i].tolim = (1 << TO_W) - 1; m[i].cnt = 0;
    end
    m_rdata = '0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a, logic [NCH-1:0] b);
    int ch = int'(a[7:5]);
    int r  = int'(a[4:2]);
    if (ch >= NCH) return 32'h0;
    case (r)
      0: return m[ch].sh_start;
      1: return m[ch].sh_end;
      2: return {16'h5501, 12'h000, m[ch].pend, 1'b0, 2'(m[ch].st)};
      3: return (32'(m[ch].epoch) << 1) | {31'd0, b[ch]};
      4: return {29'd0, m[ch].stat};
      5: return {29'd0, m[ch].ien};
`ifdef TBRE_MMREG_TIMEOUT_EN
      6: return 32'(m[ch].tolim);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(logic en, logic we, logic [31:0] a, logic [31:0] d,
                                     logic [NCH-1:0] b);
    mch_t nm [NCH];
    int   ch = int'(a[7:5]);
    int   r  = int'(a[4:2]);
    if (en && !we) m_rdata = model_read(a, b);
    for (int c = 0; c < NCH; c++) begin
      bit         wr  = en && we && (ch == c);
      bit         req = wr && (r == 2);
      logic [2:0] clr = '0;
      logic [2:0] set = '0;
      nm[c] = m[c];
      if (wr) begin
        if (r == 0) nm[c].sh_start = d;
        if (r == 1) nm[c].sh_end = d;
        if (r == 4) clr = d[2:0];
        if (r == 5) nm[c].ien = d[2:0];
`ifdef TBRE_MMREG_TIMEOUT_EN
        if (r == 6) nm[c].tolim = int'(d) % (1 << TO_W);
`endif
      end
      if (m[c].st == 0) begin
        if (req || m[c].pend) begin
          nm[c].st = 1; nm[c].pend = 0;
          nm[c].co_start = m[c].sh_start; nm[c].co_end = m[c].sh_end;
        end
      end else if (m[c].st == 1) begin
        nm[c].st = 2; nm[c].cnt = 0;
      end else if (m[c].st == 2) begin
        if (b[c]) nm[c].st = 3;
`ifdef TBRE_MMREG_TIMEOUT_EN
        else if (m[c].cnt == m[c].tolim) begin set[1] = 1'b1; nm[c].st = 0; end
        else nm[c].cnt = (m[c].cnt + 1) % (1 << TO_W);
`endif
      end else begin
        if (m[c].bprev && !b[c]) begin
          nm[c].epoch = (m[c].epoch + 1) % (1 << EPOCH_W);
          set[0] = 1'b1; nm[c].st = 0;
        end
      end
      if (req && m[c].st != 0) begin
        if (m[c].pend) set[2] = 1'b1;
        else nm[c].pend = 1;
      end
      nm[c].stat  = (m[c].stat & ~clr) | set;
      nm[c].bprev = b[c];
    end
    m = nm;
  endfunction

  function automatic exp_t model_out(int tcyc);
    exp_t e;
    e.cyc = tcyc; e.intr = 1'b0; e.rdata = m_rdata; e.corein = '0;
    for (int c = 0; c < NCH; c++) begin
      e.corein[65*c +: 65] = {(m[c].st == 1), m[c].co_end, m[c].co_start};
      e.intr = e.intr | (|(m[c].stat & m[c].ien));
    end
    return e;
  endfunction

  // One bus cycle: drive inputs after the edge, predict the post-edge outputs
  task automatic cyc_op(input logic en, input logic we, input logic [31:0] a, input logic [31:0] d);
    reg_en_i = en; reg_we_i = we; reg_addr_i = a; reg_wdata_i = d; tbre_busy_i = busy_v;
    model_step(en, we, a, d, busy_v);
    exp_q.push_back(model_out(cyc + 1));
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] addr(int ch, int r);
    return 32'((ch << 5) | (r << 2));
  endfunction

  task automatic wr(input int ch, input int r, input logic [31:0] d); cyc_op(1'b1, 1'b1, addr(ch, r), d); endtask
  task automatic rd(input int ch, input int r); cyc_op(1'b1, 1'b0, addr(ch, r), 32'h0); endtask
  task automatic idle(input int n); repeat (n) cyc_op(1'b0, 1'b0, 32'h0, 32'h0); endtask

  task automatic do_reset();
    @(negedge clk_i); #1;
    rstn_i = 1'b0; busy_v = '0; tbre_busy_i = '0; reg_en_i = 1'b0; reg_we_i = 1'b0;
    model_reset();
    exp_q.push_back(model_out(cyc + 1));
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  task automatic run_ch(input int ch, input int busy_len);
    wr(ch, 2, 32'h0);
    idle(2);
    busy_v[ch] = 1'b1; idle(busy_len);
    busy_v[ch] = 1'b0; idle(2);
  endtask

  // Cycle counter, advanced on every active edge
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: compare DUT outputs against the scoreboard entry for this cycle
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("corein", 160'(tbre_corein_o), 160'(e.corein));
      chk("intr",   160'(tbre_intr_o),   160'(e.intr));
      chk("rdata",  160'(reg_rdata_o),   160'(e.rdata));
    end
  end

  initial begin
    logic [31:0] a, d;
    int          ch, r, op;
    rstn_i = 1'b0; reg_en_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    busy_v = '0; tbre_busy_i = '0;
    model_reset();
    @(posedge clk_i); #1;
    exp_q.push_back(model_out(cyc + 1));
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    rd(0, 2);

    // Basic launch on ch0 with shadow update during the run
    wr(0, 0, 32'h1000); wr(0, 1, 32'h2000); wr(0, 5, 32'h1); wr(0, 2, 32'h0);
    idle(2);
    busy_v[0] = 1'b1; idle(1);
    wr(0, 0, 32'h200); idle(1);
    busy_v[0] = 1'b0; idle(2);
    rd(0, 3); rd(0, 4); rd(0, 0);
    wr(0, 4, 32'h1); rd(0, 4);

    // Pending and overflow on ch1
    wr(1, 0, 32'hA000); wr(1, 1, 32'hB000); wr(1, 2, 32'h0); idle(1);
    busy_v[1] = 1'b1; idle(2);
    wr(1, 2, 32'h0); wr(1, 2, 32'h0);
    rd(1, 2); rd(1, 4);
    busy_v[1] = 1'b0; idle(4);
    busy_v[1] = 1'b1; idle(2); busy_v[1] = 1'b0; idle(2);
    rd(1, 3); rd(1, 2);

    // Timeout behaviour
    wr(0, 4, 32'h7);
`ifdef TBRE_MMREG_TIMEOUT_EN
    wr(0, 6, 32'h5); rd(0, 6); wr(0, 2, 32'h0);
    idle(10); rd(0, 2); rd(0, 4); rd(0, 3);
    wr(0, 6, 32'hFFF);
`else
    wr(0, 6, 32'h5); rd(0, 6); wr(0, 2, 32'h0);
    idle(100); rd(0, 2); rd(0, 4);
    busy_v[0] = 1'b1; idle(2); busy_v[0] = 1'b0; idle(2);
`endif

    // Set/clear collision on done, out-of-range channel, CTRL signature
    wr(0, 2, 32'h0); idle(2);
    busy_v[0] = 1'b1; idle(2);
    busy_v[0] = 1'b0; wr(0, 4, 32'h1);
    rd(0, 4);
    wr(7, 0, 32'hDEAD_BEEF); rd(7, 0); rd(7, 2); rd(0, 2); rd(1, 7);

    // Busy while idle is ignored
    busy_v[0] = 1'b1; idle(2); busy_v[0] = 1'b0; idle(2); rd(0, 3);

    // Asynchronous reset during BUSY
    wr(0, 5, 32'h7); wr(0, 2, 32'h0); idle(2); busy_v[0] = 1'b1; idle(2);
    do_reset();
    rd(0, 2); rd(0, 3); rd(0, 4);

    // Epoch wrap with a 2-bit epoch
    for (int i = 0; i < 4; i++) begin
      run_ch(0, 2);
      rd(0, 3);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 5) == 0) busy_v[c] = ~busy_v[c];
      op = int'($urandom_range(0, 3));
      ch = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NCH - 1)) : int'($urandom_range(NCH, 7));
      r  = int'($urandom_range(0, 7));
      a  = $urandom();
      a[7:5] = 3'(ch); a[4:2] = 3'(r);
      d  = $urandom();
      if (r == 6) d = $urandom_range(0, 20);
      if (op == 1 && r == 2 && ch < NCH && m[ch].st == 0 && m[ch].pend) op = 2;
      if (op == 0 || op == 3) cyc_op(1'b0, 1'b0, a, d);
      else if (op == 1)       cyc_op(1'b1, 1'b1, a, d);
      else                    cyc_op(1'b1, 1'b0, a, d);
    end
    busy_v = '0;
    idle(4);
    @(negedge clk_i); #1;
    chk("drain", 160'(exp_q.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
